sr_cpu_mc: RTL and testbench

Multi-cycle, parametrised successor of the single-cycle schoolRISCV core.
- Executes the existing RV32I subset (add, or, srl, sltu, sub, addi, lui, beq, bne) plus jal, lw and sw.
- Instruction and data memories sit behind request/acknowledge handshakes, so the memories may insert wait states.
- Traps on illegal or misaligned operations, supports an RV32E-sized register file, and exposes a retired-instruction counter.
- Sits in the same SoC slot as the single-cycle core, between the instruction memory, a data memory and the debug register port.

---
 rtl/sr_cpu_mc.sv | 155 +++++++++++++++
 tb/tb_sr_cpu_mc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cpu_mc.sv
// Multi-cycle RV32I-subset core with handshaked instruction/data memories.
// FSM: FETCH (wait imAck) -> EXEC (decode/execute) -> MEM (wait dmAck) or TRAP (halted until reset).
module sr_cpu_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData,
  output logic        imReq,
  output logic [31:0] imAddr,
  input  logic        imAck,
  input  logic [31:0] imData,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWData,
  input  logic        dmAck,
  input  logic [31:0] dmRData,
  output logic        halt,
  output logic [31:0] instret
);
  localparam int AW = (RF_DEPTH == 16) ? 4 : 5;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;

  state_t      state;
  logic [31:0] pc, ir, ea, wData;
  logic [31:0] rf [RF_DEPTH];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1v, rs2v, immI, immS, immB, immJ, immU;
  logic [31:0] result, target, eaNext, rfWd;
  logic        legal, useRs1, useRs2, useRd, isBranch, isJal, isMem, isSt;
  logic        taken, regBad, trap, rfWe;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign immI = {{20{ir[31]}}, ir[31:20]};
  assign immS = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign immJ = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign immU = {ir[31:12], 12'd0};

  assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1[AW-1:0]];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2[AW-1:0]];

  always_comb begin
    if (regAddr == 5'd0)               regData = pc;
    else if (32'(regAddr) >= RF_DEPTH) regData = 32'd0;
    else                               regData = rf[regAddr[AW-1:0]];
  end

  always_comb begin
    legal = 1'b0; useRs1 = 1'b0; useRs2 = 1'b0; useRd = 1'b0;
    isBranch = 1'b0; isJal = 1'b0; isMem = 1'b0; isSt = 1'b0;
    result = 32'd0;
    case (opcode)
      7'b0110011: begin
        useRs1 = 1'b1; useRs2 = 1'b1; useRd = 1'b1; legal = 1'b1;
        case ({f7, f3})
          10'b0000000_000: result = rs1v + rs2v;
          10'b0100000_000: result = rs1v - rs2v;
          10'b0000000_110: result = rs1v | rs2v;
          10'b0000000_101: result = rs1v >> rs2v[4:0];
          10'b0000000_011: result = {31'd0, rs1v < rs2v};
          default:         legal = 1'b0;
        endcase
      end
      7'b0010011: begin useRs1 = 1'b1; useRd = 1'b1; legal = (f3 == 3'b000); result = rs1v + immI; end
      7'b0110111: begin useRd = 1'b1; legal = 1'b1; result = immU; end
      7'b1100011: begin useRs1 = 1'b1; useRs2 = 1'b1; isBranch = 1'b1; legal = (f3[2:1] == 2'b00); end
      7'b1101111: begin useRd = 1'b1; isJal = 1'b1; legal = 1'b1; result = pc + 32'd4; end
      7'b0000011: begin useRs1 = 1'b1; useRd = 1'b1; isMem = 1'b1; legal = (f3 == 3'b010); end
      7'b0100011: begin useRs1 = 1'b1; useRs2 = 1'b1; isMem = 1'b1; isSt = 1'b1; legal = (f3 == 3'b010); end
      default:    legal = 1'b0;
    endcase
  end

  // f3[0] selects bne: taken when the difference is non-zero
  assign taken  = isBranch && (((rs1v - rs2v) == 32'd0) ^ f3[0]);
  assign target = pc + (isJal ? immJ : immB);
  assign eaNext = rs1v + (isSt ? immS : immI);
  assign regBad = (RF_DEPTH == 16) &&
                  ((useRs1 && rs1[4]) || (useRs2 && rs2[4]) || (useRd && rd[4]));
  assign trap   = !legal || regBad || (isMem && eaNext[1:0] != 2'b00) ||
                  ((isJal || taken) && target[1]);

  always_comb begin
    rfWe = 1'b0;
    rfWd = result;
    if (state == EXEC && !trap && !isMem && !isBranch) begin
      rfWe = 1'b1;
    end else if (state == MEM && dmAck && !isSt) begin
      rfWe = 1'b1;
      rfWd = dmRData;
    end
  end

  always_ff @(posedge clk) begin
    if (rfWe && rd != 5'd0) rf[rd[AW-1:0]] <= rfWd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      instret <= 32'd0;
      ea      <= 32'd0;
      wData   <= 32'd0;
    end else begin
      case (state)
        FETCH: if (imAck) begin
          ir    <= imData;
          state <= EXEC;
        end
        EXEC: if (trap) begin
          state <= TRAP;
        end else if (isMem) begin
          ea    <= eaNext;
          wData <= rs2v;
          state <= MEM;
        end else begin
          pc      <= (isJal || taken) ? target : pc + 32'd4;
          instret <= instret + 32'd1;
          state   <= FETCH;
        end
        MEM: if (dmAck) begin
          pc      <= pc + 32'd4;
          instret <= instret + 32'd1;
          state   <= FETCH;
        end
        default: state <= TRAP;
      endcase
    end
  end

  assign imReq   = rst_n && (state == FETCH);
  assign imAddr  = {2'b00, pc[31:2]};
  assign dmReq   = (state == MEM);
  assign dmWe    = (state == MEM) && isSt;
  assign dmAddr  = ea;
  assign dmWData = wData;
  assign halt    = (state == TRAP);

endmodule

// File: tb/tb_sr_cpu_mc.sv
// Directed bench for sr_cpu_mc: stimulus queues expected bus transactions, a negedge monitor checks them.
module tb_sr_cpu_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        imReq;
  logic [31:0] imAddr;
  logic        imAck;
  logic [31:0] imData;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [31:0] dmWData;
  logic        dmAck;
  logic [31:0] dmRData;
  logic        halt;
  logic [31:0] instret;

  always #5 clk = ~clk;

  sr_cpu_mc #(.RESET_PC(32'h0000_0100), .RF_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .regAddr(regAddr), .regData(regData),
    .imReq(imReq), .imAddr(imAddr), .imAck(imAck), .imData(imData),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWData(dmWData),
    .dmAck(dmAck), .dmRData(dmRData), .halt(halt), .instret(instret)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
  } dmExp_t;

  logic [31:0] imQ[$];
  dmExp_t      dmQ[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dmCycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic chkReg(input logic [4:0] a, input logic [31:0] exp, input string name);
    regAddr = a;
    #1;
    check(name, regData, exp);
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pcExp);
    int n = 0;
    imQ.push_back(pcExp >> 2);
    while (!imReq && n < 20) begin sync(); n++; end
    if (!imReq) begin
      check("fetch-timeout", imReq, 1);
      void'(imQ.pop_back());
      return;
    end
    imData = instr;
    imAck  = 1'b1;
    sync();
    imAck  = 1'b0;
  endtask

  task automatic memAck(input logic [31:0] rdata, input int delay);
    int n = 0;
    while (!dmReq && n < 20) begin sync(); n++; end
    if (!dmReq) begin
      check("dm-timeout", dmReq, 1);
      if (dmQ.size() > 0) void'(dmQ.pop_back());
      return;
    end
    repeat (delay) sync();
    dmRData = rdata;
    dmAck   = 1'b1;
    sync();
    dmAck   = 1'b0;
  endtask

  task automatic pushDm(input logic [31:0] a, input logic we, input logic [31:0] wd, input int cyc4);
    dmExp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.cycles = cyc4;
    dmQ.push_back(e);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("reset-imReq-async", imReq, 0);
    repeat (2) sync();
    rst_n = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    dmExp_t e;
    logic [31:0] ia;
    if (!dmReq) dmCycles = 0;
    if (rst_n && imReq && imAck) begin
      if (imQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch-unexpected: imAddr=0x%0h, no fetch queued", imAddr);
      end else begin
        ia = imQ.pop_front();
        check("fetch-addr", imAddr, ia);
      end
    end
    if (rst_n && dmReq) begin
      dmCycles++;
      if (dmQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL dm-unexpected: dmAddr=0x%0h dmWe=%0d, no access queued", dmAddr, dmWe);
      end else begin
        e = dmQ[0];
        check("dm-addr", dmAddr, e.addr);
        check("dm-we", dmWe, e.we);
        if (e.we) check("dm-wdata", dmWData, e.wdata);
        check("dm-imReq-excl", imReq, 0);
        if (dmAck) begin
          void'(dmQ.pop_front());
          check("dm-req-cycles", dmCycles, e.cycles);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int seen;
    rst_n = 1'b0; regAddr = 5'd0; imAck = 1'b0; imData = 32'd0; dmAck = 1'b0; dmRData = 32'd0;
    #12;
    check("reset-imReq-low", imReq, 0);
    check("reset-dmReq", dmReq, 0);
    sync();
    rst_n = 1'b1;
    #1;
    check("reset-imReq", imReq, 1);
    check("reset-imAddr", imAddr, 32'h40);
    check("reset-instret", instret, 0);
    check("reset-halt", halt, 0);
    check("reset-dmReq-rel", dmReq, 0);
    chkReg(5'd0, 32'h100, "reset-pc");
    sync();

    // addi x1,x0,5 ; addi x2,x0,7 ; add x3,x1,x2
    c0 = cyc;
    fetch(32'h0050_0093, 32'h100);
    fetch(32'h0070_0113, 32'h104);
    fetch(32'h0020_81B3, 32'h108);
    sync();
    check("alu-cycles", cyc - c0, 6);
    check("alu-instret", instret, 3);
    chkReg(5'd3, 32'd12, "alu-x3");
    chkReg(5'd0, 32'h10C, "alu-pc");
    sync();

    // sw x3,8(x0) with 3 wait states
    pushDm(32'd8, 1'b1, 32'd12, 4);
    fetch(32'h0030_2423, 32'h10C);
    memAck(32'd0, 3);
    check("sw-instret", instret, 4);
    chkReg(5'd0, 32'h110, "sw-pc");
    sync();

    // lw x4,8(x0)
    pushDm(32'd8, 1'b0, 32'd0, 1);
    fetch(32'h0080_2203, 32'h110);
    memAck(32'd12, 0);
    chkReg(5'd4, 32'd12, "lw-x4");
    chkReg(5'd0, 32'h114, "lw-pc");
    sync();

    // bne x1,x2,-8 taken
    fetch(32'hFE20_9CE3, 32'h114);
    sync();
    chkReg(5'd0, 32'h10C, "bne-pc");
    check("bne-instret", instret, 6);
    sync();

    // beq x1,x2,+8 not taken
    fetch(32'h0020_8463, 32'h10C);
    sync();
    chkReg(5'd0, 32'h110, "beq-pc");
    sync();

    // jal x0,-0xF0 then jal x5,16 at 0x20
    fetch(32'hF11F_F06F, 32'h110);
    sync();
    chkReg(5'd0, 32'h20, "jal-back-pc");
    sync();
    fetch(32'h0100_02EF, 32'h20);
    sync();
    chkReg(5'd5, 32'h24, "jal-x5");
    chkReg(5'd0, 32'h30, "jal-pc");
    check("jal-instret", instret, 9);
    sync();

    // sub, srl, sltu, or, lui
    fetch(32'h4020_8333, 32'h30);
    fetch(32'h0013_53B3, 32'h34);
    fetch(32'h0060_B433, 32'h38);
    fetch(32'h0020_E4B3, 32'h3C);
    fetch(32'hABCD_E537, 32'h40);
    sync();
    chkReg(5'd6, 32'hFFFF_FFFE, "sub-x6");
    chkReg(5'd7, 32'h07FF_FFFF, "srl-x7");
    chkReg(5'd8, 32'd1, "sltu-x8");
    sync();
    chkReg(5'd9, 32'd7, "or-x9");
    chkReg(5'd10, 32'hABCD_E000, "lui-x10");
    chkReg(5'd20, 32'd0, "regdata-oob");
    sync();
    check("alu2-instret", instret, 14);

    // add x16,x1,x2 traps with RF_DEPTH=16
    fetch(32'h0020_8833, 32'h44);
    sync();
    check("trap-rf-halt", halt, 1);
    check("trap-rf-imReq", imReq, 0);
    check("trap-rf-instret", instret, 14);
    chkReg(5'd0, 32'h44, "trap-rf-pc");
    repeat (3) sync();
    check("trap-rf-stay", halt, 1);
    chkReg(5'd0, 32'h44, "trap-rf-pc-hold");
    sync();

    doReset();
    chkReg(5'd0, 32'h100, "rst1-pc");
    check("rst1-instret", instret, 0);
    sync();

    // lw x6,6(x0): misaligned, must trap without a data request
    fetch(32'h0060_2303, 32'h100);
    seen = 0;
    repeat (5) begin sync(); if (dmReq) seen++; end
    check("lw-mis-dmReq", seen, 0);
    check("lw-mis-halt", halt, 1);
    check("lw-mis-instret", instret, 0);
    chkReg(5'd0, 32'h100, "lw-mis-pc");
    sync();

    doReset();
    sync();

    // reset while a load is stalled in MEM
    pushDm(32'd0, 1'b0, 32'd0, 99);
    fetch(32'h0000_2383, 32'h100);
    sync();
    check("midmem-dmReq-up", dmReq, 1);
    repeat (2) sync();
    rst_n = 1'b0;
    #1;
    check("midmem-dmReq-drop", dmReq, 0);
    check("midmem-imReq-drop", imReq, 0);
    dmQ.delete();
    repeat (2) sync();
    rst_n = 1'b1;
    #1;
    check("midmem-imReq", imReq, 1);
    check("midmem-instret", instret, 0);
    chkReg(5'd0, 32'h100, "midmem-pc");
    sync();
    fetch(32'h0050_0093, 32'h100);
    sync();
    check("post-instret", instret, 1);
    chkReg(5'd1, 32'd5, "post-x1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
